// File: rtl/nv_nvdla_cvif_read_ig_wrr_arb.sv
// Weighted round-robin read-ingress arbiter with a single output register.
// Define NVDLA_CVIF_RD_ARB_PERF_EN to build the per-source grant counters.
module nv_nvdla_cvif_read_ig_wrr_arb #(
  parameter int NUM_SRC = 10,
  parameter int PD_W    = 75,
  parameter int WT_W    = 8
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic [NUM_SRC-1:0]      src_vld,
  input  logic [NUM_SRC*PD_W-1:0] src_pd,
  output logic [NUM_SRC-1:0]      src_rdy,
  input  logic [NUM_SRC*WT_W-1:0] reg2dp_wt,
  output logic                    arb_out_vld,
  output logic [PD_W-1:0]         arb_out_pd,
  output logic [3:0]              arb_out_id,
  input  logic                    arb_out_rdy,
  input  logic                    perf_clr,
  output logic [NUM_SRC*32-1:0]   dp2reg_gnt_cnt
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = WT_W + 1;

  typedef logic [CW-1:0] cr_t;

  cr_t              cred_q   [NUM_SRC];
  cr_t              cred_d   [NUM_SRC];
  cr_t              cred_eff [NUM_SRC];
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    last_d;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic             vld_q;
  logic             slot;
  logic             refill;
  logic             found;
  logic             any_gnt;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] elig_eff;
  logic [NUM_SRC-1:0] gnt;
  logic [PD_W-1:0]  pd_sel;
  logic [PD_W-1:0]  pd_q;
  logic [3:0]       id_q;

  // Gating with reset keeps src_rdy low while reset is held.
  assign slot = (!vld_q || arb_out_rdy) && nvdla_core_rstn;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = src_vld[i] && (cred_q[i] != '0);
    end
    refill = slot && (|src_vld) && !(|elig);
    for (int i = 0; i < NUM_SRC; i++) begin
      cred_eff[i] = cred_q[i];
      if (refill) begin
        if (reg2dp_wt[i*WT_W +: WT_W] == '0) begin
          cred_eff[i] = CW'(1);
        end else begin
          cred_eff[i] = CW'(reg2dp_wt[i*WT_W +: WT_W]);
        end
      end
    end
    // Refilled credits are all non-zero, so every requester qualifies.
    elig_eff = refill ? src_vld : elig;
  end

  always_comb begin
    win   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = IW'((int'(last_q) + k) % NUM_SRC);
      if (!found && elig_eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_gnt = slot && found;
  assign last_d  = any_gnt ? win : last_q;

  always_comb begin
    gnt    = '0;
    pd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt[i] = any_gnt && (win == IW'(i));
      if (gnt[i]) begin
        pd_sel = src_pd[i*PD_W +: PD_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cred_d[i] = cred_eff[i] - CW'(gnt[i]);
    end
  end

  assign src_rdy = gnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld_q  <= 1'b0;
      last_q <= IW'(NUM_SRC - 1);
      for (int i = 0; i < NUM_SRC; i++) begin
        cred_q[i] <= '0;
      end
    end else if (slot) begin
      vld_q  <= any_gnt;
      last_q <= last_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        cred_q[i] <= cred_d[i];
      end
    end
  end

  // Payload and id carry no reset; vld_q qualifies them.
  always_ff @(posedge nvdla_core_clk) begin
    if (any_gnt) begin
      pd_q <= pd_sel;
      id_q <= 4'(win);
    end
  end

  assign arb_out_vld = vld_q;
  assign arb_out_pd  = pd_q;
  assign arb_out_id  = id_q;

`ifdef NVDLA_CVIF_RD_ARB_PERF_EN
  logic [31:0] cnt_q [NUM_SRC];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (perf_clr) begin
          cnt_q[i] <= '0;
        end else if (gnt[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    dp2reg_gnt_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dp2reg_gnt_cnt[i*32 +: 32] = cnt_q[i];
    end
  end
`else
  logic perf_clr_unused;

  assign perf_clr_unused = perf_clr;
  assign dp2reg_gnt_cnt  = '0;
`endif

endmodule
